bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of each requester data word and of data_out.
REQ-002 Parameter TIMEOUT, default 15, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_a / req_b  input  1 each  requester A/B wants the shared path.
REQ-006 done_a / done_b  input  1 each  owning requester releases the path; sampled only while that requester holds the grant.
REQ-007 data_a / data_b  input  DATA_W each  requester data into the shared 2:1 word mux.
REQ-008 gnt_a / gnt_b  output  1 each  registered grant; the two are never high together.
REQ-009 sel  output  1  mux select: 0 passes data_a, 1 passes data_b.
REQ-010 data_out  output  DATA_W  mux output; all zeros when no grant is active.
REQ-011 valid  output  1  gnt_a OR gnt_b.
REQ-012 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-013 FSM states: IDLE, OWN_A, OWN_B; gnt_a=1 only in OWN_A, gnt_b=1 only in OWN_B.
REQ-014 The grant is registered: a request seen at edge N produces a grant after edge N, so latency is 1 cycle from request to grant.
REQ-015 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; neither -> stay IDLE.
REQ-016 IDLE with both requests set: grant goes to the requester that did not hold the last grant (round-robin pointer `last`).
REQ-017 OWN_x is held while req_x=1 and done_x=0; requests from the other side are ignored for ownership.
REQ-018 Release: OWN_x ends on done_x=1 or req_x=0.
  - Other requester requesting in that cycle -> direct handoff to its OWN state, with no IDLE bubble.
  - Otherwise -> IDLE.
REQ-019 `last` updates to x on every exit from OWN_x, including forced exit.
REQ-020 sel holds its value in IDLE (sticky) and is 1 exactly in OWN_B.
REQ-021 data_out = valid ? (sel ? data_b : data_a) : 0; combinational, 0-cycle path from data inputs.
REQ-022 The same requester re-asserting req_x in the cycle after its own release, with the other side idle, regains the grant after one IDLE cycle.

Reset
REQ-023 While rst_n=0, regardless of clk:
  - state=IDLE; gnt_a=gnt_b=0; valid=0; sel=0; timeout=0; data_out=0.
  - last=B, so A wins the first contested arbitration.
  - timeout counter=0.
REQ-024 Reset asserted mid-grant drops the grant immediately; no done handshake is required.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to any OWN state and increments each cycle in OWN.
  - When the counter reaches TIMEOUT-1 and the owner has not released, the grant is revoked at the next edge.
  - timeout pulses high for one cycle, in the first cycle after revocation.
  - Transition per REQ-018 as if the owner had released.
REQ-026 Macro ARB_TIMEOUT_EN undefined: no counter is built; timeout is tied to 0; grants are unbounded.

Structure
REQ-027 Shared package holds:
  - the state encoding typedef (IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10);
  - requester ID constants REQ_A=0, REQ_B=1;
  - the DATA_W default.
REQ-028 The word mux is one sub-module, mux_word, instantiated once and built from the existing 1-bit mux cell per bit; the FSM and counter stay in bus_arbiter.

Verification
REQ-029 Reset release, req_a=1 at cycle 0 -> gnt_a=1 after edge 1, sel=0, data_out=data_a (e.g. 16'h1234), valid=1.
REQ-030 req_a=req_b=1 from IDLE after reset -> A granted; done_a pulse at cycle 5 -> gnt_b=1 after next edge, no IDLE cycle, sel=1, data_out=data_b.
REQ-031 Both requests held, each owner pulses done after 3 cycles -> grants alternate A,B,A,B; neither requester is granted twice in a row.
REQ-032 gnt_b active, rst_n pulled low mid-cycle -> gnt_b=0, data_out=0 immediately; after release, req_a and req_b both set -> A granted.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT=4, req_a held with no done, req_b=1 -> gnt_a high exactly 4 cycles, timeout pulses 1 cycle, gnt_b follows; with the macro undefined, gnt_a stays high for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the two-requester bus arbiter
// Contents:
//   arb_state_e  FSM state encoding (IDLE, OWN_A, OWN_B)
//   REQ_A/REQ_B  requester IDs, also the encoding of the round-robin pointer
//   DATA_W_DEF   default data word width
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/mux_cell.sv
// rtl/mux_cell.sv - 1-bit 2:1 mux cell
// Ports:
//   sel  in   0 selects a, 1 selects b
//   a,b  in   data bits
//   y    out  selected bit
module mux_cell (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_word.sv
// rtl/mux_word.sv - W-bit 2:1 word mux built from one mux_cell per bit
// Ports:
//   sel  in   0 selects a, 1 selects b
//   a,b  in   W-bit data words
//   y    out  W-bit selected word
module mux_word #(
  parameter int W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    mux_cell u_cell (
      .sel (sel),
      .a   (a[i]),
      .b   (b[i]),
      .y   (y[i])
    );
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-requester arbiter driving a shared word mux
// Optional feature macro: ARB_TIMEOUT_EN (bounds each grant to TIMEOUT cycles)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_a, req_b      requests for the shared path
//   done_a, done_b    release from the current owner
//   data_a, data_b    requester data words
//   gnt_a, gnt_b      registered grants (one-hot or zero)
//   sel               mux select, 1 only while B owns, sticky while idle
//   data_out          selected word, zero when no grant is active
//   valid             a grant is active
//   timeout           one-cycle pulse after a forced revocation
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              done_a,
  input  logic              done_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              timeout
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic       expire;
  logic [DATA_W-1:0] mux_y;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       timeout_q;
  logic       owner_release;

  assign owner_release = (state_q == OWN_A) ? (done_a | ~req_a) : (done_b | ~req_b);
  // Revoke only when the owner is still holding on in its last allowed cycle.
  assign expire = (state_q != IDLE) && !owner_release && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      // A handoff A->B is also an entry, so compare against the current state.
      if (state_d != IDLE && state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign timeout = timeout_q;
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT);
  assign expire         = 1'b0;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= REQ_B;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_q == REQ_B) ? OWN_A : OWN_B;
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (done_a || !req_a || expire) begin
          last_d  = REQ_A;
          state_d = req_b ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (done_b || !req_b || expire) begin
          last_d  = REQ_B;
          state_d = req_a ? OWN_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // sel follows the owner and keeps its value through IDLE.
    case (state_d)
      OWN_A:   sel_d = 1'b0;
      OWN_B:   sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  assign gnt_a = (state_q == OWN_A);
  assign gnt_b = (state_q == OWN_B);
  assign valid = gnt_a | gnt_b;
  assign sel   = sel_q;

  mux_word #(.W(DATA_W)) u_mux (
    .sel (sel_q),
    .a   (data_a),
    .b   (data_b),
    .y   (mux_y)
  );

  assign data_out = valid ? mux_y : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a behavioural model
module tb_bus_arbiter;

  localparam int DW = 16;
  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, req_b, done_a, done_b;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, sel, valid, timeout;
  logic [DW-1:0] data_out;

  bus_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .done_a   (done_a),
    .done_b   (done_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .data_out (data_out),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner 0=none 1=A 2=B; last = previous owner; held = cycles of current grant.
  int   m_owner, m_last, m_held, m_to_cnt;
  logic m_sel, m_to;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_data;
    exp_data = (m_owner == 1) ? data_a : (m_owner == 2) ? data_b : '0;
    chk({tag, ".gnt_a"},    DW'(gnt_a),   DW'(m_owner == 1));
    chk({tag, ".gnt_b"},    DW'(gnt_b),   DW'(m_owner == 2));
    chk({tag, ".valid"},    DW'(valid),   DW'(m_owner != 0));
    chk({tag, ".sel"},      DW'(sel),     DW'(m_sel));
    chk({tag, ".timeout"},  DW'(timeout), DW'(m_to));
    chk({tag, ".data_out"}, data_out,     exp_data);
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_held  = 0;
    m_sel   = 1'b0;
    m_to    = 1'b0;
  endtask

  // Predict the effect of the coming edge from the present inputs, then clock and compare.
  task automatic step(input string tag);
    int nxt;
    bit rel, forced, oth_req;
    forced = 1'b0;
    if (m_owner == 0) begin
      if (req_a && req_b) nxt = (m_last == 2) ? 1 : 2;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
      else                nxt = 0;
    end else begin
      rel     = (m_owner == 1) ? (done_a || !req_a) : (done_b || !req_b);
      oth_req = (m_owner == 1) ? req_b : req_a;
      forced  = TO_EN && !rel && (m_held == TO);
      if (rel || forced) begin
        m_last = m_owner;
        nxt    = oth_req ? 3 - m_owner : 0;
      end else begin
        nxt = m_owner;
      end
    end
    m_held = (nxt == 0) ? 0 : (nxt == m_owner) ? m_held + 1 : 1;
    m_to   = forced;
    if (forced) m_to_cnt++;
    if (nxt == 1) m_sel = 1'b0;
    else if (nxt == 2) m_sel = 1'b1;
    m_owner = nxt;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    done_a = 1'b0;
    done_b = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int arun;
    int to_seen;
    bit stopped;
    data_a = 16'h1234;
    data_b = 16'hbeef;
    m_to_cnt = 0;

    // Reset state, with a request present so data_out gating is exercised.
    do_reset();
    rst_n = 1'b0;
    req_a = 1'b1;
    #2;
    check_all("reset_req");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request: grant after one edge, A's word on the bus.
    step("req_a_only");
    chk("req_a_only.dout_const", data_out, 16'h1234);

    // Contested start: A wins, done_a hands straight to B.
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    step("contest");
    chk("contest.gnt_a_const", DW'(gnt_a), DW'(1'b1));
    for (int i = 0; i < 3; i++) step("contest_hold");
    done_a = 1'b1;
    step("handoff");
    done_a = 1'b0;
    chk("handoff.gnt_b_const", DW'(gnt_b), DW'(1'b1));
    chk("handoff.dout_const", data_out, 16'hbeef);

    // Both held, each owner releases after 3 cycles: strict alternation.
    for (int g = 0; g < 6; g++) begin
      step("alt_hold");
      step("alt_hold");
      if (gnt_a) done_a = 1'b1;
      else       done_b = 1'b1;
      step("alt_switch");
      done_a = 1'b0;
      done_b = 1'b0;
    end

    // Owner re-requests right after its own release with the other side idle.
    do_reset();
    req_a = 1'b1;
    step("rereq_grant");
    done_a = 1'b1;
    req_a  = 1'b0;
    step("rereq_release");
    done_a = 1'b0;
    req_a  = 1'b1;
    step("rereq_idle");
    step("rereq_regain");

    // Reset mid-grant drops gnt_b at once; A then wins the contest.
    do_reset();
    req_b = 1'b1;
    step("mid_gnt_b");
    step("mid_gnt_b2");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    chk("mid_rst.dout_const", data_out, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    step("post_rst_contest");
    chk("post_rst.gnt_a_const", DW'(gnt_a), DW'(1'b1));

    // Owner never releases while the other side waits.
    do_reset();
    req_a    = 1'b1;
    req_b    = 1'b1;
    arun     = 0;
    to_seen  = 0;
    stopped  = 1'b0;
    m_to_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step("hog");
      if (!stopped) begin
        if (gnt_a) arun++;
        else       stopped = 1'b1;
      end
      if (timeout) to_seen++;
    end
    chk("hog.gnt_a_run", DW'(arun), TO_EN ? DW'(TO) : DW'(100));
    chk("hog.timeout_pulses", DW'(to_seen), DW'(m_to_cnt));

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_a  = ($urandom % 4) != 0;
      req_b  = ($urandom % 4) != 0;
      done_a = ($urandom % 6) == 0;
      done_b = ($urandom % 6) == 0;
      data_a = DW'($urandom);
      data_b = DW'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
